// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register: registered in_ready, main + skid entry, flush-to-bubble.
// Optional stall/flush statistics counters enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_buf #(
  parameter int CTRL_W   = 16,
  parameter int DATA_W   = 192,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = 2'(state_q);

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // A same-cycle out_fire has already been consumed downstream; nothing to keep.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (state_q != EMPTY) && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline stage register that replaces the fixed-field, enable/clear stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field with valid/ready handshaking and a 2-entry skid buffer. Upstream can therefore keep a fully registered ready while downstream stalls. A flush converts the stage into a bubble with all control bits zeroed.

Parameters:
CTRL_W, 16, width of control bundle (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ...); zeroed on bubble/flush
DATA_W, 192, width of data bundle (operands, PC, PC+4, immediate, register indices)
CLR_DATA, 0, 1 = flush and reset also zero the data entries; 0 = flush leaves data entries unchanged (control zeroing alone kills the instruction)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; highest priority after reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept; driven directly from a register
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  stage holds a valid instruction
out_ready  input  1  downstream accepts (equivalent to ~Stall of the next stage)
out_ctrl  output  CTRL_W  control bundle; all zero whenever out_valid=0
out_data  output  DATA_W  data bundle of the head entry
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry holds a ctrl field and a data field. State is EMPTY, ONE or FULL; occupancy is 0, 1 or 2 respectively.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = registered (state != FULL). It is never combinationally dependent on out_ready.
- out_valid = (state != EMPTY). out_ctrl = main.ctrl when out_valid is 1, otherwise all zero.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE, in_fire & out_fire -> ONE, main <= in.
  - ONE, in_fire & !out_fire -> FULL, skid <= in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - FULL: out_fire -> ONE, main <= skid. No input is accepted because in_ready=0.
  - Otherwise the state holds and entries are unchanged. The data field is never altered while stalled.
- Latency: one cycle from in_fire to out_valid when EMPTY. Throughput is one per cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry always drains before any newer entry.
- Flush (synchronous, clocked):
  - state <= EMPTY.
  - Both ctrl fields <= 0.
  - Data fields <= 0 if CLR_DATA=1, otherwise unchanged.
  - in_ready <= 1.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle is still a valid transfer, because downstream sampled the head before the edge.
- Reset (asynchronous, any time, including mid-transfer):
  - state=EMPTY, occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
  - All ctrl fields and all data fields = 0, regardless of CLR_DATA.
- in_valid is ignored while in_ready=0. No X propagation from in_ctrl or in_data when in_valid=0.

Optional Feature:
PIPE_STAGE_STATS_EN:
- Defined: adds output ports stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while state != EMPTY.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by reset only.
- Undefined: these ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Reset mid-FULL (occupancy=2), reset asserted between edges -> immediately occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
- Streaming: out_ready=1, inputs ctrl=1..8 on consecutive cycles -> out_ctrl=1..8 one cycle later, in_ready constantly 1, occupancy=1.
- Stall: push A=0x11, B=0x22 with out_ready=0 -> occupancy=2 and in_ready=0 next cycle. Offer C=0x33 (not accepted). Release out_ready -> output order 0x11, 0x22, 0x33, with no loss and no duplication.
- Flush while FULL with in_valid=1 (ctrl=0x7) -> next cycle occupancy=0, out_ctrl=0. With CLR_DATA=0, out_data is unchanged; the 0x7 entry never appears at the output.
- Flush with out_ready=1 in the same cycle -> head entry counted as transferred, stage empty afterwards. With CLR_DATA=1, out_data=0.
- With PIPE_STAGE_STATS_EN: hold out_ready=0 for 5 cycles with out_valid=1, then flush once while non-empty -> stall_cnt=5, flush_cnt=1.
